ram_parity_reader: RTL and testbench
====================================

RAM_PARITY_READER -- requirements
Module: ram_parity_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning RAM data word width excluding the parity bit.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning RAM address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request to begin a scan; sampled in IDLE only.
REQ-006 SHALL have port base_addr, input, ADDR_WIDTH, first word address, sampled with start.
REQ-007 SHALL have port length, input, ADDR_WIDTH+1, word count (0..2^ADDR_WIDTH), sampled with start.
REQ-008 SHALL have port mem_addr, output, ADDR_WIDTH, registered address to the RAM.
REQ-009 SHALL have port mem_we, output, 1, active-low RAM write enable, constant 1 (never writes).
REQ-010 SHALL have port mem_rdata, input, DATA_WIDTH+1, RAM word: [DATA_WIDTH:1] data, [0] stored parity = XOR of data bits.
REQ-011 SHALL have port mem_raddr, input, ADDR_WIDTH, registered address echoed by the RAM.
REQ-012 SHALL have port out_data, output, DATA_WIDTH, checked data word.
REQ-013 SHALL have port out_err, output, 1, the out_data word failed its check.
REQ-014 SHALL have port out_valid, output, 1, out_data/out_err valid.
REQ-015 SHALL have port out_ready, input, 1, consumer accepts the word when out_valid and out_ready are both 1.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at scan end.
REQ-018 SHALL have port err_count, output, ADDR_WIDTH+1, number of failed words in the current/last scan.
REQ-019 SHALL have port first_err_addr, output, ADDR_WIDTH, address of first failed word.
REQ-020 SHALL have ports par_err and addr_err, output, 1 each, sticky flags per scan.

Function
REQ-021 SHALL implement states IDLE, ISSUE, HOLD, DONE.
REQ-022 IDLE + start: latch base_addr into mem_addr, length into remaining count, clear err_count/first_err_addr/par_err/addr_err; go ISSUE if length!=0, else DONE.
REQ-023 ISSUE lasts exactly one cycle; RAM captures mem_addr at the mid-cycle falling edge; at the closing rising edge, sample mem_rdata/mem_raddr into out_data/out_err, set out_valid, go HOLD.
REQ-024 Parity check: error when XOR(mem_rdata[DATA_WIDTH:1]) != mem_rdata[0]; sets par_err.
REQ-025 Address check: error when mem_raddr != mem_addr at the sample edge; sets addr_err.
REQ-026 out_err = parity error OR address error; err_count increments by 1 per failed word; first_err_addr loads only on the first failure of a scan.
REQ-027 HOLD: out_valid=1, out_data/out_err stable until out_ready=1.
REQ-028 HOLD with out_ready=1: clear out_valid, decrement remaining; if remaining was 1 go DONE, else mem_addr+1 and go ISSUE.
REQ-029 mem_addr increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00 at default width).
REQ-030 Throughput SHALL be one word per 2 cycles when out_ready is held 1.
REQ-031 DONE lasts one cycle with done=1, busy=1, then IDLE.
REQ-032 start while busy SHALL be ignored; scan parameters unaffected.
REQ-033 err_count, first_err_addr, par_err, addr_err SHALL hold after DONE until the next accepted start.

Reset
REQ-034 rst_n=0 SHALL immediately, without a clock, force IDLE and all outputs to 0 except mem_we=1.
REQ-035 Reset mid-scan SHALL abandon the scan with no done pulse; first start after release begins a fresh scan.

Verification
REQ-036 RAM words 0x10..0x12 = {0x03,p0},{0x07,p1},{0x00,p0}, base=0x10, len=3, out_ready=1 -> 3 words with out_err=0, done 6 cycles after ISSUE entry, err_count=0.
REQ-037 Word 0x20 = {0x07,p0} (bad parity), base=0x1F, len=3 -> second word out_err=1, par_err=1, err_count=1, first_err_addr=0x20.
REQ-038 base=0xFE, len=4 -> mem_addr sequence 0xFE,0xFF,0x00,0x01; done after 4th accept.
REQ-039 out_ready=0 for 5 cycles in HOLD -> out_data stable, mem_addr unchanged, no extra RAM reads; resumes on out_ready=1.
REQ-040 len=0 -> done next cycle, no out_valid; mem_raddr forced !=mem_addr -> addr_err=1; rst_n low mid-scan -> outputs 0 immediately, no done.

Source files
------------

// File: rtl/ram_parity_reader.sv
// ram_parity_reader
//   Scans a block of RAM words starting at base_addr, checking each word's
//   stored even-parity bit and that the RAM echoes the address it was given.
//   Each checked word is presented on a valid/ready output port; per-scan
//   error statistics stay visible until the next accepted start.
//
// Ports
//   clk            : single clock, rising edge active
//   rst_n          : asynchronous active-low reset
//   start          : begin a scan (sampled in IDLE only)
//   base_addr      : first word address, sampled with start
//   length         : word count 0..2^ADDR_WIDTH, sampled with start
//   mem_addr       : registered RAM address
//   mem_we         : active-low RAM write enable, tied inactive
//   mem_rdata      : RAM word, [DATA_WIDTH:1] data, [0] stored parity
//   mem_raddr      : address echoed back by the RAM
//   out_data       : checked data word
//   out_err        : out_data failed parity or address check
//   out_valid      : out_data/out_err valid
//   out_ready      : consumer accepts when out_valid && out_ready
//   busy           : FSM not in IDLE
//   done           : one-cycle pulse at scan end
//   err_count      : failed words in the current/last scan
//   first_err_addr : address of the first failed word
//   par_err        : sticky parity failure flag for the scan
//   addr_err       : sticky address-echo failure flag for the scan
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | address on mem_addr; RAM read completes, word sampled at closing edge
// HOLD  | word presented on out_*, waiting for out_ready
// DONE  | one-cycle done pulse, then IDLE
module ram_parity_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH:0]   mem_rdata,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  par_err,
  output logic                  addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic                  w_load;
  logic                  w_sample;
  logic                  w_advance;
  logic                  w_par_bad;
  logic                  w_addr_bad;
  logic                  w_word_bad;

  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_err;
  logic                  r_out_valid;
  logic [ADDR_WIDTH:0]   r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  r_par_err;
  logic                  r_addr_err;

  assign w_par_bad  = (^mem_rdata[DATA_WIDTH:1]) != mem_rdata[0];
  assign w_addr_bad = mem_raddr != r_mem_addr;
  assign w_word_bad = w_par_bad | w_addr_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_sample  = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = (length != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        w_sample = 1'b1;
        w_next   = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_advance = 1'b1;
          w_next    = (r_remaining == CNT_ONE) ? DONE : ISSUE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr       <= '0;
      r_remaining      <= '0;
      r_out_data       <= '0;
      r_out_err        <= 1'b0;
      r_out_valid      <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_par_err        <= 1'b0;
      r_addr_err       <= 1'b0;
    end else begin
      if (w_load) begin
        r_mem_addr       <= base_addr;
        r_remaining      <= length;
        r_err_count      <= '0;
        r_first_err_addr <= '0;
        r_par_err        <= 1'b0;
        r_addr_err       <= 1'b0;
      end
      if (w_sample) begin
        r_out_data  <= mem_rdata[DATA_WIDTH:1];
        r_out_err   <= w_word_bad;
        r_out_valid <= 1'b1;
        if (w_par_bad)  r_par_err  <= 1'b1;
        if (w_addr_bad) r_addr_err <= 1'b1;
        if (w_word_bad) begin
          r_err_count <= r_err_count + CNT_ONE;
          // count is cleared at start, so zero means no failure yet this scan
          if (r_err_count == '0) r_first_err_addr <= r_mem_addr;
        end
      end
      if (w_advance) begin
        r_out_valid <= 1'b0;
        r_remaining <= r_remaining - CNT_ONE;
        // the last word leaves mem_addr on its address; wrap is natural
        if (r_remaining != CNT_ONE) r_mem_addr <= r_mem_addr + ADDR_ONE;
      end
    end
  end

  assign mem_addr       = r_mem_addr;
  assign mem_we         = 1'b1;
  assign out_data       = r_out_data;
  assign out_err        = r_out_err;
  assign out_valid      = r_out_valid;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign par_err        = r_par_err;
  assign addr_err       = r_addr_err;

endmodule

// File: tb/tb_ram_parity_reader.sv
// Bench for ram_parity_reader: behavioural RAM that captures mem_addr on the
// falling edge, a queue of expected words filled when a scan is started, and
// a table of scans followed by stall, reset and busy-start sequences.
module tb_ram_parity_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic       out_ready = 1'b1;
  logic [8:0] mem_rdata = '0;
  logic [7:0] mem_raddr = '0;

  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [8:0] err_count;
  logic [7:0] first_err_addr;
  logic       par_err;
  logic       addr_err;

  ram_parity_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_raddr(mem_raddr), .out_data(out_data),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .par_err(par_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  logic [8:0] ram [256];
  bit         cor_en = 1'b0;
  logic [7:0] cor_a = '0;

  always @(negedge clk) begin
    mem_rdata <= ram[mem_addr];
    mem_raddr <= (cor_en && mem_addr == cor_a) ? (mem_addr ^ 8'h01) : mem_addr;
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    bit         rnd;
    bit         restart;
    bit         cen;
    logic [7:0] ca;
    int         exp_cyc;
    logic [8:0] errc;
    logic [7:0] first;
    bit         par;
    bit         aerr;
  } vec_t;
  vec_t vecs[8];

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic word_bad(input logic [7:0] a);
    return ((^ram[a][8:1]) != ram[a][0]) || (cor_en && a == cor_a);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_word: got data 0x%0h at 0x%0h, want no word", out_data, mem_addr);
      end else begin
        sb_e = sb_q.pop_front();
        chk("word_data", 32'(out_data), 32'(sb_e.data));
        chk("word_err", 32'(out_err), 32'(sb_e.err));
        chk("word_addr", 32'(mem_addr), 32'(sb_e.addr));
      end
    end
    if (done) done_cnt++;
  end

  task automatic push_expected(input logic [7:0] b, input logic [8:0] l);
    logic [7:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 8'(i);
      sb_q.push_back('{addr: a, data: ram[a][8:1], err: word_bad(a)});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 1);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_err"}, 32'(out_err), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_first_err"}, 32'(first_err_addr), 0);
    chk({tag, "_par_err"}, 32'(par_err), 0);
    chk({tag, "_addr_err"}, 32'(addr_err), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ncyc;
    bit got;
    string t;
    t = $sformatf("v%0d", idx);
    cor_en = v.cen;
    cor_a = v.ca;
    out_ready = 1'b1;
    push_expected(v.base, v.len);
    @(posedge clk); #1;
    base_addr = v.base;
    length = v.len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ncyc = 0;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      ncyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (v.rnd) out_ready = 1'($urandom_range(0, 1));
      if (v.restart && ncyc == 2) begin
        start = 1'b1;
        base_addr = 8'h99;
        length = 9'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({t, "_done_seen"}, 32'(got), 1);
    if (v.exp_cyc != 0) chk({t, "_done_latency"}, ncyc, v.exp_cyc);
    chk({t, "_err_count"}, 32'(err_count), 32'(v.errc));
    chk({t, "_first_err"}, 32'(first_err_addr), 32'(v.first));
    chk({t, "_par_err"}, 32'(par_err), 32'(v.par));
    chk({t, "_addr_err"}, 32'(addr_err), 32'(v.aerr));
    @(negedge clk);
    chk({t, "_done_pulse_end"}, 32'(done), 0);
    chk({t, "_busy_after"}, 32'(busy), 0);
    chk({t, "_words_left"}, sb_q.size(), 0);
    chk({t, "_err_count_hold"}, 32'(err_count), 32'(v.errc));
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ncyc;
    bit   got;
    int   dc;
    logic [7:0] d;

    for (int i = 0; i < 256; i++) begin
      d = 8'(i * 37 + 5);
      ram[i] = {d, ^d};
    end
    ram[8'h10] = {8'h03, 1'b0};
    ram[8'h11] = {8'h07, 1'b1};
    ram[8'h12] = {8'h00, 1'b0};
    ram[8'h20] = {8'h07, 1'b0};
    ram[8'h22] = {8'h5A, 1'b1};

    vecs[0] = '{base:8'h10, len:9'd3,   rnd:0, restart:0, cen:0, ca:8'h00, exp_cyc:7,   errc:9'd0, first:8'h00, par:0, aerr:0};
    vecs[1] = '{base:8'h1F, len:9'd3,   rnd:0, restart:0, cen:0, ca:8'h00, exp_cyc:7,   errc:9'd1, first:8'h20, par:1, aerr:0};
    vecs[2] = '{base:8'hFE, len:9'd4,   rnd:0, restart:0, cen:0, ca:8'h00, exp_cyc:9,   errc:9'd0, first:8'h00, par:0, aerr:0};
    vecs[3] = '{base:8'h40, len:9'd5,   rnd:0, restart:0, cen:1, ca:8'h42, exp_cyc:11,  errc:9'd1, first:8'h42, par:0, aerr:1};
    vecs[4] = '{base:8'h1E, len:9'd6,   rnd:1, restart:0, cen:0, ca:8'h00, exp_cyc:0,   errc:9'd2, first:8'h20, par:1, aerr:0};
    vecs[5] = '{base:8'h80, len:9'd256, rnd:0, restart:0, cen:0, ca:8'h00, exp_cyc:513, errc:9'd2, first:8'h20, par:1, aerr:0};
    vecs[6] = '{base:8'h33, len:9'd0,   rnd:0, restart:0, cen:0, ca:8'h00, exp_cyc:1,   errc:9'd0, first:8'h00, par:0, aerr:0};
    vecs[7] = '{base:8'h10, len:9'd3,   rnd:0, restart:1, cen:0, ca:8'h00, exp_cyc:7,   errc:9'd0, first:8'h00, par:0, aerr:0};

    #3;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    // held output: five stalled cycles on the first word, then release
    cor_en = 1'b0;
    out_ready = 1'b0;
    push_expected(8'h10, 9'd2);
    @(posedge clk); #1;
    base_addr = 8'h10;
    length = 9'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'h03);
      chk("stall_addr", 32'(mem_addr), 32'h10);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("stall_done_seen", 32'(got), 1);
    chk("stall_words_left", sb_q.size(), 0);
    sb_q.delete();

    // reset in the middle of a scan that has already flagged an error
    out_ready = 1'b0;
    @(posedge clk); #1;
    base_addr = 8'h20;
    length = 9'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_err_count", 32'(err_count), 1);
    chk("pre_rst_out_err", 32'(out_err), 1);
    dc = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, dc);
    chk("midrst_idle", 32'(busy), 0);

    run_vec(vecs[1], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
